// File: rtl/booth_r4_mult_seq.sv
// rtl/booth_r4_mult_seq.sv - sequential radix-4 Booth multiplier, signed/unsigned, full 2*WIDTH product
module booth_r4_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             data_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Operands carry two extra bits so unsigned values stay positive when treated as signed.
  localparam int N  = WIDTH + 2;
  localparam int K  = WIDTH / 2 + 1;
  localparam int CW = $clog2(K + 1);
  localparam int PW = 2 * N + 1;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [N-1:0]      a_q, a_d;
  logic              signed_q, signed_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic              exc_q, exc_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic [N-1:0]      a_ext, b_ext;
  logic [N:0]        a_sx, a_x2, digit, acc_ext, sum;
  logic [PW-1:0]     step_val;
  logic [WIDTH-1:0]  prod_lo, prod_hi;

  // Extend incoming operands, decode the Booth digit and form one add-and-shift step.
  always_comb begin
    a_ext    = data_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA} : {2'b00, data_operandA};
    b_ext    = data_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB} : {2'b00, data_operandB};
    a_sx     = {a_q[N-1], a_q};
    a_x2     = {a_q, 1'b0};
    digit    = '0;
    case (prod_q[2:0])
      3'b001, 3'b010: digit = a_sx;
      3'b011:         digit = a_x2;
      3'b100:         digit = -a_x2;
      3'b101, 3'b110: digit = -a_sx;
      default:        digit = '0;
    endcase
    acc_ext  = {prod_q[PW-1], prod_q[PW-1:N+1]};
    sum      = acc_ext + digit;
    step_val = {sum[N], sum, prod_q[N:2]};
    prod_lo  = prod_q[WIDTH:1];
    prod_hi  = prod_q[2*WIDTH:WIDTH+1];
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    a_d      = a_q;
    signed_d = signed_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (ctrl_mult) begin
          a_d      = a_ext;
          prod_d   = {{N{1'b0}}, b_ext, 1'b0};
          signed_d = data_signed;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        prod_d = step_val;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_lo_d = prod_lo;
        res_hi_d = prod_hi;
        exc_d    = signed_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}}) : (prod_hi != '0);
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      a_q      <= '0;
      signed_q <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      a_q      <= a_d;
      signed_q <= signed_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = res_lo_q;
  assign data_result_hi = res_hi_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb/tb_booth_r4_mult_seq.sv - self-checking bench for booth_r4_mult_seq
module tb_booth_r4_mult_seq;

  localparam int W = 32;
  localparam int LAT = 18;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_mult;
  logic         data_signed;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic [W-1:0] data_result_hi;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  always #5 clock = ~clock;

  booth_r4_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_signed    (data_signed),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
    int           acc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    vec_t v;
    logic [63:0] p;
    if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else   p = {32'b0, a} * {32'b0, b};
    v.a   = a;
    v.b   = b;
    v.s   = s;
    v.lo  = p[31:0];
    v.hi  = p[63:32];
    v.exc = s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'b0);
    return v;
  endfunction

  task automatic push(input vec_t v);
    exp_t e;
    e.lo  = v.lo;
    e.hi  = v.hi;
    e.exc = v.exc;
    e.acc = edge_cnt + 1;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every ready pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 64'(data_resultRDY), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_lo", 64'(data_result), 64'(e.lo));
        chk("result_hi", 64'(data_result_hi), 64'(e.hi));
        chk("exception", 64'(data_exception), 64'(e.exc));
        chk("latency", 64'(edge_cnt - e.acc), 64'(LAT));
        chk("busy_at_rdy", 64'(busy), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clock);
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic do_op(input vec_t v);
    wait_idle();
    data_operandA = v.a;
    data_operandB = v.b;
    data_signed   = v.s;
    ctrl_mult     = 1'b1;
    push(v);
    @(negedge clock);
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    data_signed   = ~v.s;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lo"}, 64'(data_result), 64'd0);
    chk({tag, "_hi"}, 64'(data_result_hi), 64'd0);
    chk({tag, "_exc"}, 64'(data_exception), 64'd0);
    chk({tag, "_rdy"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   e0;

    tbl[0]  = '{a:32'hFFFFFFFD, b:32'h00000007, s:1'b1, lo:32'hFFFFFFEB, hi:32'hFFFFFFFF, exc:1'b0};
    tbl[1]  = '{a:32'hFFFFFFFF, b:32'hFFFFFFFF, s:1'b0, lo:32'h00000001, hi:32'hFFFFFFFE, exc:1'b1};
    tbl[2]  = '{a:32'h80000000, b:32'hFFFFFFFF, s:1'b1, lo:32'h80000000, hi:32'h00000000, exc:1'b1};
    tbl[3]  = '{a:32'h00010000, b:32'h00010000, s:1'b1, lo:32'h00000000, hi:32'h00000001, exc:1'b1};
    tbl[4]  = '{a:32'h80000000, b:32'h80000000, s:1'b1, lo:32'h00000000, hi:32'h40000000, exc:1'b1};
    tbl[5]  = '{a:32'h7FFFFFFF, b:32'h7FFFFFFF, s:1'b1, lo:32'h00000001, hi:32'h3FFFFFFF, exc:1'b1};
    tbl[6]  = '{a:32'hFFFFFFFF, b:32'hFFFFFFFF, s:1'b1, lo:32'h00000001, hi:32'h00000000, exc:1'b0};
    tbl[7]  = '{a:32'h80000000, b:32'h00000002, s:1'b0, lo:32'h00000000, hi:32'h00000001, exc:1'b1};
    tbl[8]  = '{a:32'hFFFFFFFF, b:32'h00000001, s:1'b0, lo:32'hFFFFFFFF, hi:32'h00000000, exc:1'b0};
    tbl[9]  = '{a:32'h00000000, b:32'h80000000, s:1'b1, lo:32'h00000000, hi:32'h00000000, exc:1'b0};
    for (int i = 10; i < 12; i++) tbl[i] = model($urandom, $urandom, 1'(i & 1));

    reset         = 1'b1;
    ctrl_mult     = 1'b0;
    data_signed   = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #2;
    chk_all_zero("reset_state");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Table vectors; the first is driven so it is accepted on the first edge after reset.
    for (int i = 0; i < 12; i++) do_op(tbl[i]);

    // Outputs hold after the ready pulse.
    repeat (5) @(negedge clock);
    chk("hold_lo", 64'(data_result), 64'(tbl[11].lo));
    chk("hold_hi", 64'(data_result_hi), 64'(tbl[11].hi));
    chk("hold_exc", 64'(data_exception), 64'(tbl[11].exc));

    // Start request while busy is ignored.
    wait_idle();
    v = '{a:32'd5, b:32'd6, s:1'b1, lo:32'd30, hi:32'd0, exc:1'b0};
    data_operandA = v.a;
    data_operandB = v.b;
    data_signed   = v.s;
    ctrl_mult     = 1'b1;
    push(v);
    @(negedge clock);
    ctrl_mult = 1'b0;
    repeat (3) @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    wait_drain();
    repeat (25) @(negedge clock);
    chk("ignored_restart", 64'(data_result), 64'd30);
    chk("ignored_restart_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation.
    wait_idle();
    data_operandA = 32'h00001234;
    data_operandB = 32'h00005678;
    data_signed   = 1'b0;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    repeat (7) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    chk("no_rdy_after_abort", 64'(data_resultRDY), 64'd0);
    do_op('{a:32'd2, b:32'd3, s:1'b0, lo:32'd6, hi:32'd0, exc:1'b0});

    // Continuous start request with operands changing every cycle.
    wait_idle();
    e0 = edge_cnt + 1;
    ctrl_mult = 1'b1;
    while (edge_cnt + 1 < e0 + 3 * (LAT + 1)) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      data_signed   = 1'($urandom);
      if (((edge_cnt + 1 - e0) % (LAT + 1)) == 0) push(model(data_operandA, data_operandB, data_signed));
      @(negedge clock);
    end
    ctrl_mult = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_mult_seq.md
BOOTH_R4_MULT_SEQ -- requirements
Module: booth_r4_mult_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be even and >= 4, otherwise elaboration SHALL fail.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ctrl_mult  input  1  start request; sampled at rising edge.
REQ-005 Port: data_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-006 Port: data_operandA  input  WIDTH  multiplicand.
REQ-007 Port: data_operandB  input  WIDTH  multiplier.
REQ-008 Port: data_result  output  WIDTH  low WIDTH bits of the product.
REQ-009 Port: data_result_hi  output  WIDTH  high WIDTH bits of the product.
REQ-010 Port: data_exception  output  1  product not representable in WIDTH bits.
REQ-011 Port: data_resultRDY  output  1  one-cycle pulse marking new valid results.
REQ-012 Port: busy  output  1  high while an operation is in progress.
REQ-013 Clocking SHALL be a single clock domain; reset SHALL be asynchronous and active-high.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE, ctrl_mult=1 at an edge SHALL accept an operation: capture A, B and data_signed, clear the step counter, and enter RUN.
REQ-016 Internal operands SHALL be extended to N=WIDTH+2 bits, sign-extended if data_signed=1 and zero-extended otherwise.
REQ-017 The product register SHALL be 2N+1 bits wide: accumulator, multiplier, and an appended 0 bit.
REQ-018 Each RUN edge SHALL decode the low 3 bits of the product register to a digit in {0, +-A, +-2A}.
REQ-019 Each RUN edge SHALL add that digit to the accumulator (N+1 bits, no truncation).
REQ-020 Each RUN edge SHALL then arithmetic-shift the whole register right by 2, replicating the sign bit into both vacated MSBs.
REQ-021 RUN SHALL perform exactly K=WIDTH/2+1 steps, then enter DONE.
REQ-022 DONE SHALL, in one edge, do the following and then return to IDLE:
- register the low 2*WIDTH product bits into data_result_hi:data_result;
- compute and register data_exception;
- set data_resultRDY=1.
REQ-023 Latency: data_resultRDY SHALL be high in the cycle after the L-th rising edge following the accepting edge, where L=WIDTH/2+2 (18 for WIDTH=32).
REQ-024 data_resultRDY SHALL be high for exactly one cycle per accepted operation.
REQ-025 data_result, data_result_hi and data_exception SHALL hold their values until the next DONE edge or reset.
REQ-026 busy SHALL be 1 in RUN and DONE and 0 in IDLE; it SHALL fall on the same edge that raises data_resultRDY.
REQ-027 ctrl_mult while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-028 Operand, data_signed or ctrl_mult changes after acceptance SHALL NOT affect the in-flight result.
REQ-029 With ctrl_mult held high continuously, a new operation SHALL be accepted every L+1 edges, i.e. on the edge after data_resultRDY is high.
REQ-030 data_exception, signed mode: SHALL be 1 iff data_result_hi is not all copies of data_result[WIDTH-1].
REQ-031 data_exception, unsigned mode: SHALL be 1 iff data_result_hi != 0.
REQ-032 Results SHALL equal the exact mathematical product for all operand pairs in both modes, including -2^(WIDTH-1) operands and all-ones unsigned operands.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for a clock edge, force state IDLE, clear the counter and product register, and drive data_result=0, data_result_hi=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-034 Reset during RUN or DONE SHALL abort the operation with no data_resultRDY pulse.
REQ-035 The first edge after reset deasserts SHALL accept ctrl_mult normally.

Verification (WIDTH=32)
REQ-036 Signed -3 x 7 (A=0xFFFFFFFD, B=0x00000007, signed=1) -> result=0xFFFFFFEB, hi=0xFFFFFFFF, exception=0, data_resultRDY 18 edges after accept.
REQ-037 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001, hi=0xFFFFFFFE, exception=1.
REQ-038 Signed 0x80000000 x 0xFFFFFFFF -> result=0x80000000, hi=0x00000000, exception=1; signed 0x00010000 x 0x00010000 -> result=0, hi=1, exception=1.
REQ-039 Accept 5 x 6, then pulse ctrl_mult with 9 x 9 at edge 4 -> single data_resultRDY, result=30; the 9 x 9 request is never executed.
REQ-040 Assert reset asynchronously at mid-cycle 7 of an operation -> all outputs 0 immediately and no data_resultRDY; after release, 2 x 3 -> result=6 at 18 edges.
REQ-041 Hold ctrl_mult high with changing operands -> accepts exactly 19 edges apart; each result matches the operands present at its accepting edge.
